gate_share_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one 2-input logic gate instance among NUM_REQ

---
 rtl/gate_share_arbiter.sv | 108 ++++++++++
 tb/tb_gate_share_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_share_arbiter.sv
// Round-robin sequencer that time-shares one 2-input gate cell among NUM_REQ requesters.
// Each operation spends one cycle in IDLE (grant), GATE_LAT cycles in EXEC and one in RESP (done).
module gate_share_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int GATE_LAT = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] a_in_i,
  input  logic [NUM_REQ-1:0] b_in_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [NUM_REQ-1:0] done_o,
  output logic               result_o,
  output logic               gate_a_o,
  output logic               gate_b_o,
  input  logic               gate_y_i,
  output logic               busy_o
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (GATE_LAT > 1) ? $clog2(GATE_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e             state_q;
  logic [PW-1:0]      ptr_q, win_q, ptr_d;
  logic [CW-1:0]      cnt_q;
  logic [NUM_REQ-1:0] grant_q, done_q;
  logic               result_q, ga_q, gb_q, busy_q;

  logic               pick_vld;
  logic [PW-1:0]      pick_idx;

  // Scan offsets high-to-low so the smallest offset from the pointer is the last to win.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (req_i[idx]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(idx);
      end
    end
  end

  assign ptr_d = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      result_q <= 1'b0;
      ga_q     <= 1'b0;
      gb_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if (pick_vld) begin
            grant_q <= NUM_REQ'(1) << pick_idx;
            win_q   <= pick_idx;
            ga_q    <= a_in_i[pick_idx];
            gb_q    <= b_in_i[pick_idx];
            cnt_q   <= CW'(GATE_LAT - 1);
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            result_q <= gate_y_i;
            done_q   <= grant_q;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          done_q  <= '0;
          grant_q <= '0;
          ga_q    <= 1'b0;
          gb_q    <= 1'b0;
          busy_q  <= 1'b0;
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o  = grant_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign gate_a_o = ga_q;
  assign gate_b_o = gb_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_gate_share_arbiter.sv
// Directed bench: u1 runs with GATE_LAT=1, u3 with GATE_LAT=3; both drive an AND cell.
module tb_gate_share_arbiter;

  logic       clk = 1'b0;
  logic       rst, rst3;
  logic [3:0] req, a, b, grant, done;
  logic [3:0] req3, a3, b3, grant3, done3;
  logic       result, ga, gb, gy, busy;
  logic       result3, ga3, gb3, gy3, busy3;

  int checks   = 0;
  int failures = 0;

  int idx_q[$];
  int cyc_q[$];
  logic res_q[$];

  always #5 clk = ~clk;

  assign gy  = ga & gb;
  assign gy3 = ga3 & gb3;

  gate_share_arbiter #(.NUM_REQ(4), .GATE_LAT(1)) u1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .a_in_i(a), .b_in_i(b),
    .grant_o(grant), .done_o(done), .result_o(result),
    .gate_a_o(ga), .gate_b_o(gb), .gate_y_i(gy), .busy_o(busy));

  gate_share_arbiter #(.NUM_REQ(4), .GATE_LAT(3)) u3 (
    .clk_i(clk), .rst_i(rst3), .req_i(req3), .a_in_i(a3), .b_in_i(b3),
    .grant_o(grant3), .done_o(done3), .result_o(result3),
    .gate_a_o(ga3), .gate_b_o(gb3), .gate_y_i(gy3), .busy_o(busy3));

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic reset1();
    rst = 1'b1; req = '0; a = '0; b = '0;
    step(2);
    rst = 1'b0;
  endtask

  // Collects done pulses of u1; optionally drops each requester's bit in its done cycle.
  task automatic run1(input int n, input int budget, input bit drop);
    idx_q.delete(); cyc_q.delete(); res_q.delete();
    for (int c = 1; c <= budget && idx_q.size() < n; c++) begin
      step(1);
      if (done != 4'b0) begin
        idx_q.push_back(oh_idx(done));
        cyc_q.push_back(c);
        res_q.push_back(result);
        checks++;
        if ((grant & done) !== done) begin
          failures++;
          $display("FAIL done_vs_grant: done=%b grant=%b", done, grant);
        end
        if (drop) req = req & ~done;
      end
    end
    req = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst3 = 1'b1;
    req = '0; a = '0; b = '0; req3 = '0; a3 = '0; b3 = '0;
    step(2);
    rst = 1'b0; rst3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({grant, done, busy, ga, gb, result} !== 12'b0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: grant=%b done=%b busy=%b ga=%b gb=%b res=%b exp all 0",
                 i, grant, done, busy, ga, gb, result);
      end
      step(1);
    end
    checks++;
    if ({grant3, done3, busy3, ga3, gb3} !== 11'b0) begin
      failures++;
      $display("FAIL reset_u3: grant=%b done=%b busy=%b exp 0", grant3, done3, busy3);
    end
  endtask

  task automatic test_single();
    req = 4'b0001; a = 4'b0001; b = 4'b0001;
    step(1);
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1 || ga !== 1'b1 || gb !== 1'b1 || done !== 4'b0) begin
      failures++;
      $display("FAIL single_grant: grant=%b busy=%b ga=%b gb=%b done=%b exp 0001/1/1/1/0000",
               grant, busy, ga, gb, done);
    end
    step(1);
    checks++;
    if (done !== 4'b0001 || result !== 1'b1 || grant !== 4'b0001) begin
      failures++;
      $display("FAIL single_done: done=%b result=%b grant=%b exp 0001/1/0001", done, result, grant);
    end
    req = 4'b0000;
    step(1);
    checks++;
    if (grant !== 4'b0 || done !== 4'b0 || busy !== 1'b0 || ga !== 1'b0) begin
      failures++;
      $display("FAIL single_release: grant=%b done=%b busy=%b ga=%b exp 0", grant, done, busy, ga);
    end
  endtask

  task automatic test_rotation();
    int exp_idx[5] = '{0, 1, 2, 3, 0};
    logic exp_res[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    reset1();
    req = 4'b1111; a = 4'b0101; b = 4'b1111;
    run1(5, 40, 1'b0);
    step(2);
    checks++;
    if (idx_q.size() != 5) begin
      failures++;
      $display("FAIL rotation_timeout: got %0d dones exp 5", idx_q.size());
    end else begin
      checks++;
      if (cyc_q[0] != 2) begin
        failures++;
        $display("FAIL rotation_latency: first done at %0d exp 2", cyc_q[0]);
      end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (idx_q[i] != exp_idx[i] || res_q[i] !== exp_res[i]) begin
          failures++;
          $display("FAIL rotation_%0d: idx=%0d res=%b exp idx=%0d res=%b",
                   i, idx_q[i], res_q[i], exp_idx[i], exp_res[i]);
        end
        if (i > 0) begin
          checks++;
          if (cyc_q[i] - cyc_q[i-1] != 3) begin
            failures++;
            $display("FAIL rotation_gap_%0d: gap=%0d exp 3", i, cyc_q[i] - cyc_q[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_wrap();
    reset1();
    req = 4'b0010; a = 4'b0011; b = 4'b0001;
    run1(1, 10, 1'b1);
    step(2);
    checks++;
    if (idx_q.size() != 1 || idx_q[0] != 1 || res_q[0] !== 1'b0) begin
      failures++;
      $display("FAIL wrap_setup: n=%0d exp requester 1 result 0", idx_q.size());
    end
    req = 4'b0011;
    run1(2, 20, 1'b1);
    step(2);
    checks++;
    if (idx_q.size() != 2) begin
      failures++;
      $display("FAIL wrap_timeout: got %0d dones exp 2", idx_q.size());
    end else begin
      checks++;
      if (idx_q[0] != 0 || idx_q[1] != 1 || res_q[0] !== 1'b1 || res_q[1] !== 1'b0) begin
        failures++;
        $display("FAIL wrap_order: idx=%0d,%0d res=%b,%b exp 0,1 res 1,0",
                 idx_q[0], idx_q[1], res_q[0], res_q[1]);
      end
    end
  endtask

  task automatic test_latch();
    int extra;
    // Pointer is 2 after the wrap scenario.
    req = 4'b0100; a = 4'b0100; b = 4'b0100;
    step(1);
    checks++;
    if (grant !== 4'b0100 || ga !== 1'b1) begin
      failures++;
      $display("FAIL latch_grant: grant=%b ga=%b exp 0100/1", grant, ga);
    end
    a = 4'b0000; req = 4'b0000;
    step(1);
    checks++;
    if (done !== 4'b0100 || result !== 1'b1 || ga !== 1'b1) begin
      failures++;
      $display("FAIL latch_done: done=%b result=%b ga=%b exp 0100/1/1", done, result, ga);
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (done != 4'b0) extra++;
    end
    checks++;
    if (extra != 0 || ga !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL latch_once: extra_dones=%0d ga=%b busy=%b exp 0/0/0", extra, ga, busy);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    req3 = 4'b0010; a3 = 4'b0010; b3 = 4'b0010;
    step(1);
    checks++;
    if (grant3 !== 4'b0010 || busy3 !== 1'b1) begin
      failures++;
      $display("FAIL lat3_grant: grant=%b busy=%b exp 0010/1", grant3, busy3);
    end
    step(2);
    checks++;
    if (done3 !== 4'b0) begin
      failures++;
      $display("FAIL lat3_early: done=%b exp 0000", done3);
    end
    step(1);
    checks++;
    if (done3 !== 4'b0010 || result3 !== 1'b1) begin
      failures++;
      $display("FAIL lat3_done: done=%b result=%b exp 0010/1", done3, result3);
    end
    req3 = 4'b0000;
    step(1);
    req3 = 4'b0100; a3 = 4'b0100; b3 = 4'b0100;
    step(2);
    rst3 = 1'b1; req3 = 4'b0000;
    step(1);
    checks++;
    if (grant3 !== 4'b0 || busy3 !== 1'b0 || done3 !== 4'b0 || ga3 !== 1'b0) begin
      failures++;
      $display("FAIL abort_state: grant=%b busy=%b done=%b ga=%b exp 0", grant3, busy3, done3, ga3);
    end
    rst3 = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (done3 != 4'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_nodone: saw %0d dones exp 0", seen);
    end
    req3 = 4'b0101; a3 = 4'b0101; b3 = 4'b0001;
    seen = -1;
    for (int i = 0; i < 12 && seen < 0; i++) begin
      step(1);
      if (done3 != 4'b0) seen = oh_idx(done3);
    end
    req3 = 4'b0000;
    checks++;
    if (seen != 0 || result3 !== 1'b1) begin
      failures++;
      $display("FAIL abort_ptr: winner=%0d result=%b exp 0/1", seen, result3);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_latch();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
